// File: rtl/mem_bus_ctrl.sv
// Memory subsystem behind the CPU bus: RAM with programmable wait states plus a small IO register block.
// Optional write protection of the low RAM words is enabled with the MEMBUS_ROM_PROTECT_EN macro.
module mem_bus_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int RAM_AW   = 15,
  parameter int RAM_WAIT = 1,
  parameter int ROM_TOP  = 256,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] led,
  output logic              irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [ADDR_W-1:0] IO_BASE = ADDR_W'(1) << RAM_AW;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] led_q, led_d, ien_q, ien_d;
  logic              stat_q, stat_d;
  logic [DATA_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sw_prev_q, sw_prev_d;
  logic [DATA_W-1:0] io_rd_q, io_rd_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic [DATA_W-1:0] ram_rd_q;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_idx;
  logic [ADDR_W-1:0] io_off;
  logic              is_ram, req_is_ram, io_err, prot_hit;
  logic [DATA_W-1:0] io_val;

  assign ram_idx    = addr_q[RAM_AW-1:0];
  assign is_ram     = addr_q < IO_BASE;
  assign req_is_ram = req_addr < IO_BASE;
  assign io_off     = addr_q - IO_BASE;
  assign io_err     = !is_ram && (io_off >= ADDR_W'(4));

`ifdef MEMBUS_ROM_PROTECT_EN
  localparam logic [RAM_AW:0] ROM_TOP_W = ROM_TOP[RAM_AW:0];
  assign prot_hit = is_ram && we_q && ({1'b0, ram_idx} < ROM_TOP_W);
`else
  logic unused_rom_top;
  assign unused_rom_top = ROM_TOP[0];
  assign prot_hit = 1'b0;
`endif

  always_comb begin
    io_val = '0;
    case (io_off[1:0])
      2'd0: io_val = led_q;
      2'd1: io_val = sw_s2_q;
      2'd2: io_val = ien_q;
      default: io_val = {{(DATA_W-1){1'b0}}, stat_q};
    endcase
    if (io_err) io_val = '0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    led_d       = led_q;
    ien_d       = ien_q;
    stat_d      = stat_q;
    io_rd_d     = io_rd_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ram_we      = 1'b0;
    sw_s1_d     = sw_in;
    sw_s2_d     = sw_s1_q;
    sw_prev_d   = sw_s2_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_is_ram && (RAM_WAIT > 0)) begin
            state_d = S_WAIT;
            cnt_d   = 4'(RAM_WAIT);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        err_d   = io_err || prot_hit;
        io_rd_d = io_val;
        if (we_q) begin
          if (is_ram) begin
            ram_we = !prot_hit;
          end else if (!io_err) begin
            case (io_off[1:0])
              2'd0: led_d = wdata_q;
              2'd2: ien_d = wdata_q;
              2'd3: if (wdata_q[0]) stat_d = 1'b0;
              default: ;
            endcase
          end
        end
        state_d = S_RESP;
      end
      default: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (we_q || err_q) ? '0 : (is_ram ? ram_rd_q : io_rd_q);
        state_d     = S_IDLE;
      end
    endcase

    // A switch change on the same edge as a software clear keeps the flag set.
    if (sw_s2_q != sw_prev_q) stat_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      led_q       <= '0;
      ien_q       <= '0;
      stat_q      <= 1'b0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      sw_prev_q   <= '0;
      io_rd_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      led_q       <= led_d;
      ien_q       <= ien_d;
      stat_q      <= stat_d;
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      sw_prev_q   <= sw_prev_d;
      io_rd_q     <= io_rd_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Plain clocked array so it maps to block RAM; the read register is loaded on the ACCESS edge.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= wdata_q;
    ram_rd_q <= ram[ram_idx];
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign led       = led_q;
  assign irq       = stat_q & ien_q[0];

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: vector table of single requests plus reset, IRQ and protection sequences.
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err, irq;
  logic [7:0]  rsp_rdata, sw_in, led;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sw_in(sw_in), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic er, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble the request fields to show they are not used after acceptance.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 16'h8003;
    req_wdata = 8'hFF;
    chk("ready_low_busy", {31'd0, req_ready}, 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) break;
    end
    rd = rsp_rdata;
    er = rsp_err;
    $display("req we=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d", we, addr, wd, rd, er, lat);
  endtask

  task automatic run_chk(input string name, input logic we, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] erd, input logic eer, input int elat);
    logic [7:0] rd;
    logic       er;
    int         lat;
    do_req(we, addr, wd, rd, er, lat);
    chk({name, "_rdata"}, {24'd0, rd}, {24'd0, erd});
    chk({name, "_err"}, {31'd0, er}, {31'd0, eer});
    chk({name, "_lat"}, lat, elat);
  endtask

`ifdef MEMBUS_ROM_PROTECT_EN
  localparam logic [15:0] RST_ADDR = 16'h0120;
`else
  localparam logic [15:0] RST_ADDR = 16'h0020;
`endif

  initial begin
    int   k;
    logic seen;

    vecs[0]  = '{1'b1, 16'h0110, 8'hA5, 8'h00, 1'b0, 3};
    vecs[1]  = '{1'b0, 16'h0110, 8'h00, 8'hA5, 1'b0, 3};
    vecs[2]  = '{1'b1, 16'h0111, 8'h5A, 8'h00, 1'b0, 3};
    vecs[3]  = '{1'b0, 16'h0111, 8'h00, 8'h5A, 1'b0, 3};
    vecs[4]  = '{1'b0, 16'h0110, 8'h00, 8'hA5, 1'b0, 3};
    vecs[5]  = '{1'b1, 16'h7FFF, 8'hC3, 8'h00, 1'b0, 3};
    vecs[6]  = '{1'b0, 16'h7FFF, 8'h00, 8'hC3, 1'b0, 3};
    vecs[7]  = '{1'b1, 16'h8000, 8'h3C, 8'h00, 1'b0, 2};
    vecs[8]  = '{1'b0, 16'h8000, 8'h00, 8'h3C, 1'b0, 2};
    vecs[9]  = '{1'b0, 16'h8005, 8'h00, 8'h00, 1'b1, 2};
    vecs[10] = '{1'b1, 16'h8007, 8'hFF, 8'h00, 1'b1, 2};
    vecs[11] = '{1'b1, 16'h8001, 8'h77, 8'h00, 1'b0, 2};
    vecs[12] = '{1'b0, 16'h8001, 8'h00, 8'h00, 1'b0, 2};
    vecs[13] = '{1'b1, 16'h8002, 8'h01, 8'h00, 1'b0, 2};
    vecs[14] = '{1'b0, 16'h8002, 8'h00, 8'h01, 1'b0, 2};
    vecs[15] = '{1'b0, 16'h8003, 8'h00, 8'h00, 1'b0, 2};
    vecs[16] = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b1, 2};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sw_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    #2 rst = 1'b0;

    for (int i = 0; i < NV; i++)
      run_chk($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);

    chk("led_mirror", {24'd0, led}, 32'h3C);
    chk("irq_idle", {31'd0, irq}, 32'd0);

    // Switch edge propagates through the synchroniser into IO_STAT and raises irq.
    @(negedge clk);
    sw_in = 8'h01;
    k = 0;
    while (k < 3) begin
      @(posedge clk);
      #1;
      k++;
      if (irq) break;
    end
    chk("irq_set", {31'd0, irq}, 32'd1);
    run_chk("rd_sw", 1'b0, 16'h8001, 8'h00, 8'h01, 1'b0, 2);
    run_chk("rd_stat", 1'b0, 16'h8003, 8'h00, 8'h01, 1'b0, 2);
    run_chk("clr_stat", 1'b1, 16'h8003, 8'h01, 8'h00, 1'b0, 2);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

`ifdef MEMBUS_ROM_PROTECT_EN
    run_chk("rom_wr", 1'b1, 16'h0004, 8'hFF, 8'h00, 1'b1, 3);
    run_chk("rom_rd", 1'b0, 16'h0004, 8'h00, 8'h00, 1'b0, 3);
    run_chk("rom_top_wr", 1'b1, 16'h0100, 8'h42, 8'h00, 1'b0, 3);
    run_chk("rom_top_rd", 1'b0, 16'h0100, 8'h00, 8'h42, 1'b0, 3);
`else
    run_chk("wr_0010", 1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0, 3);
    run_chk("rd_0010", 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0, 3);
    run_chk("wr_0004", 1'b1, 16'h0004, 8'hFF, 8'h00, 1'b0, 3);
    run_chk("rd_0004", 1'b0, 16'h0004, 8'h00, 8'hFF, 1'b0, 3);
`endif

    // Reset lands in WAIT of a write: the write must be lost and no response produced.
    run_chk("pre_wr", 1'b1, RST_ADDR, 8'h11, 8'h00, 1'b0, 3);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = RST_ADDR; req_wdata = 8'h99;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_led", {24'd0, led}, 32'd0);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_rst_no_rsp", {31'd0, seen}, 32'd0);
    run_chk("post_rst_rd", 1'b0, RST_ADDR, 8'h00, 8'h11, 1'b0, 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
